// File: rtl/raven_bus_pkg.sv
// Shared definitions for the 68000 bus-cycle logic: FSM state encoding,
// the interrupt-acknowledge function code and chip-select region indices.
package raven_bus_pkg;

  // Bus-cycle terminator states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // no cycle in progress
    ST_WAIT = 3'd1,  // counting down wait states
    ST_ACK  = 3'd2,  // dtack_n asserted
    ST_IACK = 3'd3,  // vpa_n asserted (autovector)
    ST_HANG = 3'd4,  // no decodable target, waiting for release or timeout
    ST_ERR  = 3'd5   // berr_n asserted
  } bus_state_t;

  // Function code that marks an interrupt-acknowledge cycle
  localparam logic [2:0] FC_IACK = 3'b111;

  // Bit positions of the decoded chip selects in the region vector
  localparam int REGION_ROM  = 0;
  localparam int REGION_RAM  = 1;
  localparam int REGION_IO   = 2;
  localparam int NUM_REGIONS = 3;

  // True when exactly one region select is active
  function automatic logic is_onehot3(input logic [NUM_REGIONS-1:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/bus_timeout.sv
// Bus-cycle watchdog. A free-running edge counter that is cleared on strobe
// acceptance and emits a single-cycle 'expired' pulse during the clock period
// that ends with edge (acceptance + TIMEOUT_CYCLES). The counter saturates at
// all-ones so the pulse cannot repeat within one long cycle.
// Only instantiated when DTACK_BERR_TIMEOUT_EN is defined.
module bus_timeout #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  // Counter value seen just before the edge that completes the timeout
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  // Next count: restart on acceptance, otherwise climb and stick at the top
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (count_reg != CNT_MAX) begin
      count_next = count_reg + 1'b1;
    end
  end

  // Edge counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign expired = !clr && (count_reg == EXPIRE_AT);

endmodule

// File: rtl/dtack_gen.sv
// 68000 bus-cycle terminator. Accepts a strobe, decodes the target region,
// inserts per-region wait states and then drives dtack_n; answers
// interrupt-acknowledge cycles with vpa_n. Undecodable cycles hang.
// Optional feature macro: DTACK_BERR_TIMEOUT_EN -- adds the bus_timeout
// watchdog so hung or over-long cycles terminate with berr_n. Without it
// berr_n is tied high and the ERR state is never entered.
module dtack_gen #(
  parameter int WS_ROM         = 2,
  parameter int WS_RAM         = 0,
  parameter int WS_IO          = 3,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       as_n,
  input  logic [2:0] fc,
  input  logic       sel_rom,
  input  logic       sel_ram,
  input  logic       sel_io,
  output logic       dtack_n,
  output logic       vpa_n,
  output logic       berr_n,
  output logic       busy
);

  import raven_bus_pkg::*;

  bus_state_t state_reg;
  bus_state_t state_next;

  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic [NUM_REGIONS-1:0] sel_vec;
  logic [CNT_W-1:0]       ws_table [NUM_REGIONS];
  logic [CNT_W-1:0]       ws_sel;
  logic                   accept;
  logic                   expired;
  logic                   dtack_n_reg;
  logic                   vpa_n_reg;
  logic                   busy_reg;

  // Region select vector and wait-state lookup, indexed by region
  assign sel_vec[REGION_ROM]  = sel_rom;
  assign sel_vec[REGION_RAM]  = sel_ram;
  assign sel_vec[REGION_IO]   = sel_io;
  assign ws_table[REGION_ROM] = CNT_W'(WS_ROM);
  assign ws_table[REGION_RAM] = CNT_W'(WS_RAM);
  assign ws_table[REGION_IO]  = CNT_W'(WS_IO);

  // Wait-state count of the selected region (meaningful only when one-hot)
  always_comb begin
    ws_sel = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (sel_vec[i]) begin
        ws_sel = ws_table[i];
      end
    end
  end

`ifdef DTACK_BERR_TIMEOUT_EN
  logic berr_n_reg;

  bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_bus_timeout (
    .clk     (clk_in),
    .rst_n   (reset),
    .clr     (accept),
    .expired (expired)
  );

  // Bus error strobe follows entry into / exit from ERR
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      berr_n_reg <= 1'b1;
    end else begin
      berr_n_reg <= (state_next != ST_ERR);
    end
  end

  assign berr_n = berr_n_reg;
`else
  assign expired = 1'b0;
  assign berr_n  = 1'b1;
`endif

  // Next-state decode: acceptance, wait countdown, release and abort
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!as_n) begin
          accept = 1'b1;
          if (fc == FC_IACK) begin
            state_next = ST_IACK;
          end else if (is_onehot3(sel_vec)) begin
            cnt_next   = ws_sel;
            state_next = (ws_sel == '0) ? ST_ACK : ST_WAIT;
          end else begin
            state_next = ST_HANG;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = (cnt_reg != '0) ? cnt_reg - 1'b1 : '0;
        if (as_n) begin
          // Strobe withdrawn before acknowledge: abort silently
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(1)) begin
          // Acknowledge takes precedence over a coincident timeout
          state_next = ST_ACK;
        end else if (expired) begin
          state_next = ST_ERR;
        end
      end
      ST_HANG: begin
        if (as_n) begin
          state_next = ST_IDLE;
        end else if (expired) begin
          state_next = ST_ERR;
        end
      end
      ST_ACK, ST_IACK, ST_ERR: begin
        if (as_n) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State and wait-state counter registers
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Registered strobes and busy, decoded from the state being entered
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      dtack_n_reg <= 1'b1;
      vpa_n_reg   <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      dtack_n_reg <= (state_next != ST_ACK);
      vpa_n_reg   <= (state_next != ST_IACK);
      busy_reg    <= (state_next != ST_IDLE);
    end
  end

  assign dtack_n = dtack_n_reg;
  assign vpa_n   = vpa_n_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_dtack_gen.sv
// Randomised self-checking bench for dtack_gen. Each bus cycle is described
// by its kind and the number of edges the strobe is held low; the expected
// outputs on every edge come from the cycle-level timing rules.
module tb_dtack_gen;

  localparam int WS_ROM  = 2;
  localparam int WS_RAM  = 0;
  localparam int WS_IO   = 3;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 7;
`ifdef DTACK_BERR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int K_ROM   = 0;
  localparam int K_RAM   = 1;
  localparam int K_IO    = 2;
  localparam int K_IACK  = 3;
  localparam int K_NONE  = 4;
  localparam int K_MULTI = 5;
  localparam int NEVER   = 1 << 30;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic       as_n   = 1'b1;
  logic [2:0] fc     = 3'b000;
  logic       sel_rom = 1'b0;
  logic       sel_ram = 1'b0;
  logic       sel_io  = 1'b0;
  logic       dtack_n;
  logic       vpa_n;
  logic       berr_n;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  dtack_gen #(
    .WS_ROM         (WS_ROM),
    .WS_RAM         (WS_RAM),
    .WS_IO          (WS_IO),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (CNT_W)
  ) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .as_n    (as_n),
    .fc      (fc),
    .sel_rom (sel_rom),
    .sel_ram (sel_ram),
    .sel_io  (sel_io),
    .dtack_n (dtack_n),
    .vpa_n   (vpa_n),
    .berr_n  (berr_n),
    .busy    (busy)
  );

  // Compare packed {dtack_n, vpa_n, berr_n, busy}
  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %b expected %b ({dtack_n,vpa_n,berr_n,busy})", tag, obs, exp);
    end
  endtask

  // Expected outputs after edge t of a cycle (t=0 is acceptance) whose
  // strobe is sampled low on edges 0..len-1 and high on edge len.
  function automatic logic [3:0] model(input int kind, input int t, input int len);
    int ack_at;
    int err_at;
    if (t >= len) return 4'b1110;
    if (kind == K_IACK) return 4'b1011;
    case (kind)
      K_ROM:   ack_at = WS_ROM;
      K_RAM:   ack_at = WS_RAM;
      K_IO:    ack_at = WS_IO;
      default: ack_at = NEVER;
    endcase
    err_at = TO_EN ? TIMEOUT : NEVER;
    if (ack_at <= err_at) begin
      if (t >= ack_at) return 4'b0111;
    end else if (t >= err_at) begin
      return 4'b1101;
    end
    return 4'b1111;
  endfunction

  task automatic drive_accept(input int kind);
    logic [2:0] multi_pat [4];
    logic [2:0] s;
    multi_pat[0] = 3'b011; multi_pat[1] = 3'b101;
    multi_pat[2] = 3'b110; multi_pat[3] = 3'b111;
    fc = 3'($urandom_range(0, 6));
    case (kind)
      K_ROM:   s = 3'b001;
      K_RAM:   s = 3'b010;
      K_IO:    s = 3'b100;
      K_IACK:  begin s = 3'($urandom_range(0, 7)); fc = 3'b111; end
      K_NONE:  s = 3'b000;
      default: s = multi_pat[$urandom_range(0, 3)];
    endcase
    {sel_io, sel_ram, sel_rom} = s;
  endtask

  // Inputs other than the strobe are noise once the cycle is accepted
  task automatic scramble();
    fc = 3'($urandom_range(0, 7));
    {sel_io, sel_ram, sel_rom} = 3'($urandom_range(0, 7));
  endtask

  task automatic run_cycle(input string name, input int kind, input int len, input int gap);
    for (int t = 0; t <= len; t++) begin
      @(negedge clk_in);
      if (t == 0) begin
        as_n = 1'b0;
        drive_accept(kind);
      end else begin
        as_n = (t == len);
        scramble();
      end
      @(posedge clk_in);
      #1;
      check_eq($sformatf("%s k=%0d len=%0d t=%0d", name, kind, len, t),
               {dtack_n, vpa_n, berr_n, busy}, model(kind, t, len));
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk_in);
      as_n = 1'b1;
      scramble();
      @(posedge clk_in);
      #1;
      check_eq($sformatf("%s idle g=%0d", name, g), {dtack_n, vpa_n, berr_n, busy}, 4'b1110);
    end
  endtask

  initial begin
    int kind;
    int len;
    // Asynchronous reset: outputs settle before any clock edge
    #2 reset = 1'b0;
    #1 check_eq("reset_state", {dtack_n, vpa_n, berr_n, busy}, 4'b1110);
    repeat (2) @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in);
    #1 check_eq("post_reset_idle", {dtack_n, vpa_n, berr_n, busy}, 4'b1110);

    // Directed cycles
    run_cycle("ram_read", K_RAM, 3, 1);
    run_cycle("io_cycle", K_IO, 6, 1);
    run_cycle("iack", K_IACK, 3, 0);
    run_cycle("unmapped", K_NONE, 70, 1);
    run_cycle("rom_io_multi", K_MULTI, 68, 0);
    run_cycle("rom_abort", K_ROM, 1, 0);
    run_cycle("ram_after_abort", K_RAM, 2, 0);
    run_cycle("ws_boundary_io", K_IO, 4, 0);
    run_cycle("ws_short_io", K_IO, 3, 2);

    // Randomised cycles, including back-to-back strobes and long holds
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 5);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(60, 70);
      else len = $urandom_range(1, 6);
      run_cycle("rand", kind, len, $urandom_range(0, 2));
    end

    // Reset while dtack_n is asserted
    @(negedge clk_in);
    as_n = 1'b0;
    fc = 3'b000;
    {sel_io, sel_ram, sel_rom} = 3'b010;
    @(posedge clk_in);
    #1 check_eq("pre_reset_ack", {dtack_n, vpa_n, berr_n, busy}, model(K_RAM, 0, 2));
    #2 reset = 1'b0;
    #1 check_eq("reset_mid_ack", {dtack_n, vpa_n, berr_n, busy}, 4'b1110);
    @(negedge clk_in);
    as_n = 1'b1;
    @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in);
    #1 check_eq("reset_not_resumed", {dtack_n, vpa_n, berr_n, busy}, 4'b1110);
    run_cycle("ram_after_reset", K_RAM, 3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
